// File: rtl/aes_pkg.sv
// Shared key-expansion types and constants.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_WORDS  = 4;
    localparam int G_TIMEOUT  = 31;

    typedef logic [31:0]             word_t;
    typedef logic [KEY_WORDS*32-1:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_G_START,
        ST_G_WAIT,
        ST_XOR,
        ST_DONE
    } kx_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_if.sv
// Control and round-key read bus of the key expansion controller.
interface key_expansion_ctrl_if;
    import aes_pkg::*;

    logic       start;
    key_t       key_in;
    logic [3:0] rd_round;
    key_t       rd_key;
    logic       busy;
    logic       done;
    logic       keys_valid;
    logic       err;

    modport master (output start, key_in, rd_round,
                    input  rd_key, busy, done, keys_valid, err);
    modport slave  (input  start, key_in, rd_round,
                    output rd_key, busy, done, keys_valid, err);
endinterface

// File: rtl/key_expansion_ctrl_g.sv
// AES G word transform (RotWord, SubWord, Rcon) with a fixed result latency.
module key_expansion_ctrl_g
    import aes_pkg::*;
#(
    parameter int LATENCY = 12
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       g_enable,
    input  word_t      g_in,
    input  logic [3:0] g_round,
    output logic       g_done,
    output word_t      g_out
);

    localparam int CW = $clog2(LATENCY + 1);

    // Entry 0x00 sits in the top byte, so byte b lives at index ~b.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    word_t         w_q;
    logic [3:0]    round_q;
    logic [CW-1:0] cnt;
    logic          run;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_q     <= '0;
            round_q <= '0;
            cnt     <= '0;
            run     <= 1'b0;
        end else if (g_enable) begin
            w_q     <= g_in;
            round_q <= g_round;
            cnt     <= CW'(LATENCY - 1);
            run     <= 1'b1;
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign g_done = run && (cnt == '0);
    assign g_out  = {SBOX[~w_q[23:16]] ^ rcon(round_q), SBOX[~w_q[15:8]],
                     SBOX[~w_q[7:0]], SBOX[~w_q[31:24]]};

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key schedule sequencer: drives the G transform once per round and
// stores all 11 round keys in a local register array.
//
// state    | meaning
// IDLE     | waiting for start; slot 0 loaded on accept
// G_START  | one-cycle g_enable with previous key's last word
// G_WAIT   | waiting for g_done, timeout counter running
// XOR      | build and store the next round key
// DONE     | final round written; flags raised on exit
module key_expansion_ctrl
    import aes_pkg::*;
#(
    parameter int G_LATENCY = 12
) (
    input logic                 clk,
    input logic                 n_rst,
    key_expansion_ctrl_if.slave bus
);

    kx_state_e  state, state_nxt;
    key_t       slot [NUM_ROUNDS+1];
    logic [3:0] round;
    logic [4:0] tmo;
    word_t      g_out_q;
    word_t      g_out;
    logic       g_enable, g_done;
    logic       accept, timeout, fin;
    logic       done_q, kv_q, err_q;
    key_t       prev;
    word_t      n0, n1, n2, n3;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (bus.start) state_nxt = ST_G_START;
            ST_G_START: state_nxt = ST_G_WAIT;
            ST_G_WAIT: begin
                if (g_done)                          state_nxt = ST_XOR;
                else if (tmo == 5'(G_TIMEOUT - 1))   state_nxt = ST_IDLE;
            end
            ST_XOR:     state_nxt = (round == 4'(NUM_ROUNDS)) ? ST_DONE : ST_G_START;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        g_enable = 1'b0;
        accept   = 1'b0;
        timeout  = 1'b0;
        fin      = 1'b0;
        case (state)
            ST_IDLE:    accept   = bus.start;
            ST_G_START: g_enable = 1'b1;
            ST_G_WAIT:  timeout  = !g_done && (tmo == 5'(G_TIMEOUT - 1));
            ST_DONE:    fin      = 1'b1;
            default:    ;
        endcase
    end

    assign prev = slot[round - 4'd1];
    assign n0   = prev[127:96] ^ g_out_q;
    assign n1   = prev[95:64]  ^ n0;
    assign n2   = prev[63:32]  ^ n1;
    assign n3   = prev[31:0]   ^ n2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) slot[i] <= '0;
            round   <= '0;
            tmo     <= '0;
            g_out_q <= '0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= fin;
            err_q  <= timeout;
            if (fin) kv_q <= 1'b1;
            if (accept) begin
                slot[0] <= bus.key_in;
                round   <= 4'd1;
                kv_q    <= 1'b0;
            end
            if (state == ST_G_START) tmo <= '0;
            if (state == ST_G_WAIT) begin
                tmo <= tmo + 1'b1;
                if (g_done) g_out_q <= g_out;
            end
            if (state == ST_XOR) begin
                slot[round] <= {n0, n1, n2, n3};
                if (round != 4'(NUM_ROUNDS)) round <= round + 4'd1;
            end
        end
    end

    key_expansion_ctrl_g #(.LATENCY(G_LATENCY)) u_g (
        .clk      (clk),
        .n_rst    (n_rst),
        .g_enable (g_enable),
        .g_in     (prev[31:0]),
        .g_round  (round),
        .g_done   (g_done),
        .g_out    (g_out)
    );

    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.keys_valid = kv_q;
    assign bus.err        = err_q;
    assign bus.rd_key     = (bus.rd_round <= 4'(NUM_ROUNDS)) ? slot[bus.rd_round] : '0;

endmodule

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to expand key_in; sampled only in IDLE.
REQ-004 SHALL have port key_in, input, 128, cipher key; word order w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
REQ-005 SHALL have port rd_round, input, 4, round-key read index 0..10.
REQ-006 SHALL have port rd_key, output, 128, combinational read of round-key slot rd_round.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when all 11 round keys are written.
REQ-009 SHALL have port keys_valid, output, 1, high from done until the next accepted start or reset.
REQ-010 SHALL have port err, output, 1, one-cycle pulse on word-transform timeout.

Function
REQ-011 SHALL implement states IDLE, G_START, G_WAIT, XOR, DONE.
REQ-012 IDLE with start=1 SHALL write key_in to slot 0, set round counter to 1, clear keys_valid, and go to G_START; start=0 stays IDLE.
REQ-013 G_START SHALL assert g_enable for exactly one cycle, with g_in = slot[round-1][31:0] and g_round = round counter, then go to G_WAIT.
REQ-014 G_WAIT SHALL hold g_enable=0, increment a 5-bit timeout counter each cycle, and on g_done=1 capture g_out and go to XOR.
REQ-015 XOR SHALL write slot[round] = {n0,n1,n2,n3}, where n0=prev.w0^g_out, n1=prev.w1^n0, n2=prev.w2^n1, n3=prev.w3^n2, and prev = slot[round-1].
REQ-016 XOR with round=10 SHALL go to DONE; otherwise it SHALL increment round and go to G_START.
REQ-017 DONE SHALL pulse done, set keys_valid, and return to IDLE the next cycle.
REQ-018 With the existing word transform (12 cycles from enable edge to done), each round SHALL take 14 cycles, and done SHALL be high 141 cycles after the start-accept edge.
REQ-019 If the timeout counter reaches 31 in G_WAIT without g_done, the block SHALL pulse err, go to IDLE, and leave keys_valid=0.
REQ-020 start while busy SHALL be ignored without side effects.
REQ-021 rd_round > 10 SHALL return rd_key = 0.
REQ-022 Reads of slots 0..10 SHALL be legal at any time; slots not yet written SHALL return their previous contents.
REQ-023 A g_done outside G_WAIT SHALL be ignored.

Reset
REQ-024 n_rst=0 SHALL force IDLE, round=0, timeout=0, and busy=done=keys_valid=err=0, and SHALL clear all 11 slots, including mid-expansion.
REQ-025 The instantiated word transform SHALL share clk and n_rst, so a reset aborts both blocks together.

Structure
REQ-026 A shared aes_pkg SHALL hold the key-expansion state enum, NUM_ROUNDS=10, KEY_WORDS=4, and G_TIMEOUT=31.
REQ-027 The block SHALL instantiate exactly one sub-module, the existing G word transform (RotWord/SubWord/Rcon), and SHALL contain no other S-box.
REQ-028 Round-key storage SHALL be an 11x128 register array inside this module.

Verification
REQ-029 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done after 141 cycles; rd_round=1 gives a0fafe1788542cb123a339392a6c7605; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 All-zero key -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, keys_valid=1.
REQ-031 start re-pulsed at cycle 50 with a different key_in -> ignored; results match the first key.
REQ-032 n_rst asserted at cycle 70 -> busy=0, keys_valid=0, all slots read 0; a new start then completes correctly.
REQ-033 Stubbed G that never raises done -> err pulses 31 cycles into G_WAIT of round 1, state returns to IDLE, keys_valid=0.
REQ-034 rd_round=15 -> rd_key=0 at all times.
